adder_share_arbiter: RTL

- Round-robin arbiter that time-shares one external single_adder (N-bit, Y = A + B) among REQS requesters, e.g. the PC+4, branch-target and address-generation paths of the processor.
- Accepts operand pairs over a valid/ready handshake and drives the adder's A/B inputs from registers.
- Captures the adder's Y output and returns it with the requester's ID over a second valid/ready handshake.
- Services one operation at a time: a non-pipelined FSM around a combinational adder.

---
 rtl/adder_share_arbiter.sv | 116 +++++++++++
 1 files changed

// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter time-sharing one external combinational adder among REQS requesters.
// One operation in flight at a time: IDLE (grant) -> COMPUTE (sample adder) -> RESP (hold result).
module adder_share_arbiter #(
  parameter int unsigned N    = 32,
  parameter int unsigned REQS = 4,
  parameter int unsigned IDW  = $clog2(REQS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REQS-1:0]      req_valid,
  input  logic [REQS*N-1:0]    req_a,
  input  logic [REQS*N-1:0]    req_b,
  output logic [REQS-1:0]      req_ready,
  output logic [N-1:0]         add_a,
  output logic [N-1:0]         add_b,
  input  logic [N-1:0]         add_y,
  output logic                 resp_valid,
  output logic [N-1:0]         resp_y,
  output logic [IDW-1:0]       resp_id,
  input  logic                 resp_ready,
  output logic                 busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    RESP    = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [IDW-1:0]    r_rr_ptr;
  logic [N-1:0]      r_add_a;
  logic [N-1:0]      r_add_b;
  logic [N-1:0]      r_resp_y;
  logic [IDW-1:0]    r_resp_id;
  logic              r_resp_valid;
  logic              r_busy;

  logic              w_found;
  logic [IDW-1:0]    w_gidx;
  logic [REQS-1:0]   w_grant;
  logic              w_hs;

  // First valid requester at or after rr_ptr, wrapping modulo REQS.
  always_comb begin : grant_search
    logic [IDW-1:0] v_idx;
    w_found = 1'b0;
    w_gidx  = '0;
    v_idx   = '0;
    for (int unsigned i = 0; i < REQS; i++) begin
      v_idx = IDW'((32'(r_rr_ptr) + i) % REQS);
      if (!w_found && req_valid[v_idx]) begin
        w_found = 1'b1;
        w_gidx  = v_idx;
      end
    end
  end

  assign w_grant   = w_found ? (REQS'(1) << w_gidx) : '0;
  assign req_ready = ((r_state == IDLE) && rst) ? w_grant : '0;

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    w_hs        = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_found) begin
          w_hs        = 1'b1;
          w_state_nxt = COMPUTE;
        end
      end
      COMPUTE: w_state_nxt = RESP;
      RESP:    if (resp_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State register and datapath; reset discards any in-flight operation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_busy       <= 1'b0;
      r_rr_ptr     <= '0;
      r_add_a      <= '0;
      r_add_b      <= '0;
      r_resp_y     <= '0;
      r_resp_id    <= '0;
      r_resp_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != IDLE);
      if (w_hs) begin
        r_add_a   <= req_a[w_gidx*N +: N];
        r_add_b   <= req_b[w_gidx*N +: N];
        r_resp_id <= w_gidx;
        r_rr_ptr  <= (w_gidx == IDW'(REQS - 1)) ? '0 : w_gidx + IDW'(1);
      end
      if (r_state == COMPUTE) begin
        r_resp_y     <= add_y;
        r_resp_valid <= 1'b1;
      end else if ((r_state == RESP) && resp_ready) begin
        r_resp_valid <= 1'b0;
      end
    end
  end

  assign add_a      = r_add_a;
  assign add_b      = r_add_b;
  assign resp_y     = r_resp_y;
  assign resp_id    = r_resp_id;
  assign resp_valid = r_resp_valid;
  assign busy       = r_busy;

endmodule
